// File: rtl/ghost_dir_if.sv
// ghost_dir_if: request/grant and direction-source signals between the ghost movers and the arbiter.
interface ghost_dir_if #(
    parameter int N_REQ = 4
) ();
    localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    logic                 freeze;
    logic [N_REQ-1:0]     req;
    logic [8*N_REQ-1:0]   cur_dir;
    logic [7:0]           src_dir;
    logic                 src_advance;
    logic [N_REQ-1:0]     ack;
    logic [8*N_REQ-1:0]   ghost_dir;
    logic                 busy;
    logic [IW-1:0]        grant_id;
    modport slave (
        input  freeze, req, cur_dir, src_dir,
        output src_advance, ack, ghost_dir, busy, grant_id
    );
    modport master (
        output freeze, req, cur_dir, src_dir,
        input  src_advance, ack, ghost_dir, busy, grant_id
    );
endinterface

// File: rtl/ghost_dir_arbiter.sv
// ghost_dir_arbiter: round-robin sharing of one random direction source among ghosts, rejecting reversals.
module ghost_dir_arbiter #(
    parameter int          N_REQ     = 4,
    parameter int          MAX_TRIES = 3,
    parameter logic [7:0]  RESET_DIR = 8'h1A
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    ghost_dir_if.slave bus
);
    localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int TW = MAX_TRIES > 1 ? $clog2(MAX_TRIES) : 1;

    typedef enum logic [1:0] {IDLE, ADV, CHECK, ACK} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        grant_q, grant_d, last_q, last_d, pick;
    logic [TW-1:0]        tries_q, tries_d;
    logic [8*N_REQ-1:0]   dir_q, dir_d;
    logic                 found, cur_ok, src_ok, reject;
    logic [7:0]           cur;

    function automatic logic is_valid(input logic [7:0] c);
        return c == 8'h04 || c == 8'h07 || c == 8'h16 || c == 8'h1A;
    endfunction

    function automatic logic [7:0] reverse(input logic [7:0] c);
        return c == 8'h04 ? 8'h07 : c == 8'h07 ? 8'h04 :
               c == 8'h16 ? 8'h1A : c == 8'h1A ? 8'h16 : 8'h00;
    endfunction

    // scan starts just after the last served ghost
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!found && bus.req[(int'(last_q) + i) % N_REQ]) begin
                found = 1'b1;
                pick  = IW'((int'(last_q) + i) % N_REQ);
            end
        end
    end

    assign cur    = bus.cur_dir[8*int'(grant_q) +: 8];
    assign cur_ok = is_valid(cur);
    assign src_ok = is_valid(bus.src_dir);
    assign reject = !src_ok || (cur_ok && bus.src_dir == reverse(cur));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        tries_d = tries_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: if (!bus.freeze && found) begin
                state_d = ADV;
                grant_d = pick;
                tries_d = '0;
            end
            ADV: state_d = CHECK;
            CHECK: begin
                if (!reject) begin
                    dir_d[8*int'(grant_q) +: 8] = bus.src_dir;
                    state_d = ACK;
                end else if (int'(tries_q) < MAX_TRIES - 1) begin
                    tries_d = tries_q + TW'(1);
                    state_d = ADV;
                end else begin
                    dir_d[8*int'(grant_q) +: 8] = cur_ok ? cur : RESET_DIR;
                    state_d = ACK;
                end
            end
            default: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(N_REQ - 1);
            tries_q <= '0;
            dir_q   <= {N_REQ{RESET_DIR}};
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            tries_q <= tries_d;
            dir_q   <= dir_d;
        end
    end

    assign bus.src_advance = state_q == ADV;
    assign bus.ack         = state_q == ACK ? (N_REQ'(1) << grant_q) : '0;
    assign bus.busy        = state_q != IDLE;
    assign bus.grant_id    = grant_q;
    assign bus.ghost_dir   = dir_q;
endmodule

// File: tb/tb_ghost_dir_arbiter.sv
// tb_ghost_dir_arbiter: transaction-level model compared every cycle, plus directed literal checks.
module tb_ghost_dir_arbiter;
    localparam int N  = 4;
    localparam int MT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ghost_dir_if #(.N_REQ(N)) bus ();
    ghost_dir_arbiter #(.N_REQ(N), .MAX_TRIES(MT), .RESET_DIR(8'h1A)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus)
    );

    int checks = 0, failures = 0;
    logic [7:0] src_q[$];
    int cyc = 0, rise_cyc = 0, ack_cyc = 0, adv_cnt = 0;
    int adv_total = 0, rise_total = 0, ack_total = 0;
    logic prev_busy = 1'b0;

    int m_t, m_e, m_k, m_g, m_last, m_last_grant;
    bit m_active;
    logic [31:0] m_dir;
    logic [7:0] m_nd, m_cur, m_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit dir_ok(input logic [7:0] s, input logic [7:0] c);
        if (!(s inside {8'h04, 8'h07, 8'h16, 8'h1A})) return 0;
        return !({c, s} inside {16'h0407, 16'h0704, 16'h161A, 16'h1A16});
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // registered random source: next entry appears on the edge after src_advance
    initial begin
        bus.src_dir = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.src_advance === 1'b1) begin
                @(posedge clk);
                #1 bus.src_dir = src_q.size() > 0 ? src_q.pop_front() : 8'h00;
            end
        end
    end

    // model: each grant becomes a timed transaction of k source samples
    initial begin
        m_active = 0; m_last = N - 1; m_last_grant = 0; m_dir = 32'h1A1A1A1A;
        m_t = 0; m_e = 0; m_g = 0; m_k = 0; m_nd = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                m_active = 0; m_last = N - 1; m_last_grant = 0; m_dir = 32'h1A1A1A1A;
            end else if (m_active && cyc == m_e) begin
                m_dir[8*m_g +: 8] = m_nd;
            end
            chk("src_advance", 32'(bus.src_advance),
                32'(m_active && ((cyc - m_t) % 2 == 1) && cyc < m_e));
            chk("ack", 32'(bus.ack), (m_active && cyc == m_e) ? 32'(1 << m_g) : 32'd0);
            chk("busy", 32'(bus.busy), 32'(m_active));
            chk("grant_id", 32'(bus.grant_id), m_active ? 32'(m_g) : 32'(m_last_grant));
            chk("ghost_dir", bus.ghost_dir, m_dir);
            if (bus.busy && !prev_busy) begin rise_cyc = cyc; adv_cnt = 0; rise_total++; end
            if (bus.src_advance) begin adv_cnt++; adv_total++; end
            if (bus.ack != 0) begin ack_cyc = cyc; ack_total++; end
            prev_busy = bus.busy;
            if (rst_n) begin
                if (m_active && cyc == m_e) begin
                    m_active = 0;
                    m_last = m_g;
                end else if (!m_active && !bus.freeze && bus.req != 0) begin
                    for (int i = 1; i <= N; i++)
                        if (bus.req[(m_last + i) % N]) begin m_g = (m_last + i) % N; break; end
                    m_cur = bus.cur_dir[8*m_g +: 8];
                    m_k = MT;
                    m_nd = (m_cur inside {8'h04, 8'h07, 8'h16, 8'h1A}) ? m_cur : 8'h1A;
                    for (int i = 0; i < MT; i++) begin
                        m_s = i < src_q.size() ? src_q[i] : 8'h00;
                        if (dir_ok(m_s, m_cur)) begin m_k = i + 1; m_nd = m_s; break; end
                    end
                    m_t = cyc; m_e = m_t + 2*m_k + 1; m_active = 1; m_last_grant = m_g;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mode 0: ack, 1: busy, 2: src_advance
    task automatic wait_sig(input int mode, input string name);
        int n = 0;
        @(negedge clk);
        while (n < 60 && !(mode == 0 ? bus.ack != 0 : mode == 1 ? bus.busy : bus.src_advance)) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (n >= 60) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got no event expected event within 60 cycles", name);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; bus.req = '0; bus.freeze = 1'b0; src_q.delete();
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int id, prev_ack, a, r;
        bus.freeze = 1'b0; bus.req = '1; bus.cur_dir = {4{8'h16}};
        tick(3);
        chk("rst_ghost_dir", bus.ghost_dir, 32'h1A1A1A1A);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        bus.req = 4'b0001; src_q.push_back(8'h04); rst_n = 1'b1;
        wait_sig(0, "t1");
        chk("t1_ack", 32'(bus.ack), 32'd1);
        chk("t1_dir0", 32'(bus.ghost_dir[7:0]), 32'h04);
        chk("t1_latency", ack_cyc - rise_cyc, 2);
        chk("t1_adv", adv_cnt, 1);
        tick(1); bus.req = '0;

        do_reset();
        bus.cur_dir = {4{8'h16}};
        repeat (12) src_q.push_back(8'h04);
        bus.req = '1;
        prev_ack = 0;
        for (int i = 0; i < 5; i++) begin
            wait_sig(0, "rr");
            id = onehot_idx(bus.ack);
            chk("rr_order", id, i % 4);
            if (i > 0) chk("rr_spacing", ack_cyc - prev_ack, 4);
            prev_ack = ack_cyc;
            tick(1);
            if (i == 4) bus.req = '0;
            else begin bus.req[id] = 1'b0; tick(1); bus.req[id] = 1'b1; end
        end
        tick(2); bus.req = 4'b0010;
        wait_sig(0, "rr_l1");
        chk("rr_last1", onehot_idx(bus.ack), 1);
        tick(1); bus.req = 4'b1001;
        wait_sig(0, "rr_g3");
        chk("rr_wrap3", onehot_idx(bus.ack), 3);
        tick(1); bus.req = 4'b0001;
        wait_sig(0, "rr_g0");
        chk("rr_wrap0", onehot_idx(bus.ack), 0);
        tick(1); bus.req = '0;

        do_reset();
        bus.cur_dir = {4{8'h07}};
        src_q = '{8'h04, 8'h04, 8'h16};
        bus.req = 4'b0001;
        wait_sig(0, "retry");
        chk("retry_dir", 32'(bus.ghost_dir[7:0]), 32'h16);
        chk("retry_adv", adv_cnt, 3);
        chk("retry_latency", ack_cyc - rise_cyc, 6);
        tick(1); bus.req = '0;

        do_reset();
        bus.cur_dir = {4{8'h16}};
        src_q = '{8'h1A, 8'h1A, 8'h00};
        bus.req = 4'b0100;
        wait_sig(0, "fb");
        chk("fb_dir", 32'(bus.ghost_dir[23:16]), 32'h16);
        chk("fb_adv", adv_cnt, 3);
        chk("fb_latency", ack_cyc - rise_cyc, 6);
        tick(1); bus.req = '0;
        bus.cur_dir[23:16] = 8'hFF;
        src_q = '{8'h00, 8'h55, 8'h00};
        tick(1); bus.req = 4'b0100;
        wait_sig(0, "fb_inv");
        chk("fb_inv_dir", 32'(bus.ghost_dir[23:16]), 32'h1A);
        chk("fb_inv_adv", adv_cnt, 3);
        tick(1); bus.req = '0;
        src_q = '{8'h1A, 8'h1A, 8'h00};
        tick(1); bus.req = 4'b0100;
        wait_sig(0, "inv_acc");
        chk("inv_acc_dir", 32'(bus.ghost_dir[23:16]), 32'h1A);
        chk("inv_acc_adv", adv_cnt, 1);
        tick(1); bus.req = '0;

        do_reset();
        bus.cur_dir = {4{8'h16}};
        src_q.push_back(8'h04);
        bus.freeze = 1'b1; bus.req = 4'b0100;
        a = adv_total; r = rise_total;
        tick(20);
        chk("frz_adv", adv_total - a, 0);
        chk("frz_busy_rise", rise_total - r, 0);
        bus.freeze = 1'b0;
        wait_sig(1, "frz_grant");
        tick(1); bus.freeze = 1'b1;
        wait_sig(0, "frz_ack");
        chk("frz_ack", 32'(bus.ack), 32'b0100);
        chk("frz_dir", 32'(bus.ghost_dir[23:16]), 32'h04);
        tick(1); bus.req = '0; bus.freeze = 1'b0;

        do_reset();
        bus.cur_dir = {4{8'h16}};
        src_q = '{8'h04, 8'h07};
        bus.req = 4'b0001;
        wait_sig(0, "ab_pre");
        tick(1); bus.req = '0;
        chk("ab_pre_dir", bus.ghost_dir, 32'h1A1A1A04);
        tick(1); bus.req = 4'b0001;
        wait_sig(2, "ab_adv");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ab_dir", bus.ghost_dir, 32'h1A1A1A1A);
        chk("ab_busy", 32'(bus.busy), 32'd0);
        chk("ab_ack", 32'(bus.ack), 32'd0);
        bus.req = '0; src_q.delete();
        a = ack_total;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        chk("ab_no_ack", ack_total - a, 0);
        chk("ab_dir_after", bus.ghost_dir, 32'h1A1A1A1A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
